// File: rtl/fft_pkg.sv
// Shared FFT definitions: controller state encoding and constant helpers
// used to size and wire the transform datapath.
package fft_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_BFLY  = 3'd2,
        S_SCALE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Ceiling log2; for the power-of-two transform lengths used here it is exact.
    function automatic int log2_int(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int bit_reverse(input int idx, input int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++) begin
            r = (r << 1) | ((idx >> i) & 1);
        end
        return r;
    endfunction

endpackage

// File: rtl/ifft_butterfly.sv
// Combinational radix-2 inverse butterfly: conjugates the forward twiddle,
// scales the product back by NO_FLOAT_MULT and forms a+t / a-t.
module ifft_butterfly #(
    parameter int SAMPLE_SIZE   = 32,
    parameter int TWIDDLE_SIZE  = 16,
    parameter int NO_FLOAT_MULT = 1000
) (
    input  logic signed [SAMPLE_SIZE-1:0]  a_re,
    input  logic signed [SAMPLE_SIZE-1:0]  a_im,
    input  logic signed [SAMPLE_SIZE-1:0]  b_re,
    input  logic signed [SAMPLE_SIZE-1:0]  b_im,
    input  logic signed [TWIDDLE_SIZE-1:0] w_re,
    input  logic signed [TWIDDLE_SIZE-1:0] w_im,
    output logic signed [SAMPLE_SIZE-1:0]  sum_re,
    output logic signed [SAMPLE_SIZE-1:0]  sum_im,
    output logic signed [SAMPLE_SIZE-1:0]  dif_re,
    output logic signed [SAMPLE_SIZE-1:0]  dif_im
);

    localparam int PW = SAMPLE_SIZE + TWIDDLE_SIZE + 1;
    localparam logic signed [PW-1:0] SCALE = PW'(NO_FLOAT_MULT);

    logic signed [PW-1:0]          p_re;
    logic signed [PW-1:0]          p_im;
    logic signed [SAMPLE_SIZE-1:0] t_re;
    logic signed [SAMPLE_SIZE-1:0] t_im;

    // b * conj(w) with conj(w) = w_re - j*w_im
    assign p_re = PW'(b_re) * PW'(w_re) + PW'(b_im) * PW'(w_im);
    assign p_im = PW'(b_im) * PW'(w_re) - PW'(b_re) * PW'(w_im);

    // Signed division truncates toward zero; results wrap to sample width.
    assign t_re = SAMPLE_SIZE'(p_re / SCALE);
    assign t_im = SAMPLE_SIZE'(p_im / SCALE);

    assign sum_re = a_re + t_re;
    assign sum_im = a_im + t_im;
    assign dif_re = a_re - t_re;
    assign dif_im = a_im - t_im;

endmodule

// File: rtl/ifft_n_point_seq.sv
// Sequential N-point radix-2 DIT inverse FFT, one butterfly per cycle.
// Define IFFT_SCALE_EN to add the final divide-by-N SCALE state.
module ifft_n_point_seq
    import fft_pkg::*;
#(
    parameter int SAMPLE_SIZE   = 32,
    parameter int BUFFER_SIZE   = 4,
    parameter int TWIDDLE_SIZE  = 16,
    parameter int NUM_TWIDDLES  = 16,
    parameter int NO_FLOAT_MULT = 1000
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [BUFFER_SIZE*SAMPLE_SIZE-1:0]  in_real,
    input  logic [BUFFER_SIZE*SAMPLE_SIZE-1:0]  in_imag,
    input  logic [NUM_TWIDDLES*TWIDDLE_SIZE-1:0] twiddles_real,
    input  logic [NUM_TWIDDLES*TWIDDLE_SIZE-1:0] twiddles_imag,
    output logic [BUFFER_SIZE*SAMPLE_SIZE-1:0]  out_real,
    output logic [BUFFER_SIZE*SAMPLE_SIZE-1:0]  out_imag,
    output logic                                busy,
    output logic                                done
);

    localparam int LOG_N     = log2_int(BUFFER_SIZE);
    localparam int TW_STRIDE = 2 * NUM_TWIDDLES / BUFFER_SIZE;
    localparam int TWW       = (NUM_TWIDDLES > 1) ? $clog2(NUM_TWIDDLES) : 1;
    localparam logic [LOG_N-1:0] LAST_STAGE = LOG_N'(LOG_N - 1);
    localparam logic [LOG_N-1:0] LAST_BIDX  = LOG_N'(BUFFER_SIZE / 2 - 1);

    state_t state, state_nxt;
    logic [LOG_N-1:0] stage;
    logic [LOG_N-1:0] bidx;

    logic signed [SAMPLE_SIZE-1:0]  work_re [BUFFER_SIZE];
    logic signed [SAMPLE_SIZE-1:0]  work_im [BUFFER_SIZE];
    logic signed [SAMPLE_SIZE-1:0]  nxt_re  [BUFFER_SIZE];
    logic signed [SAMPLE_SIZE-1:0]  nxt_im  [BUFFER_SIZE];
    logic signed [SAMPLE_SIZE-1:0]  ld_re   [BUFFER_SIZE];
    logic signed [SAMPLE_SIZE-1:0]  ld_im   [BUFFER_SIZE];
    logic signed [TWIDDLE_SIZE-1:0] tw_re   [NUM_TWIDDLES];
    logic signed [TWIDDLE_SIZE-1:0] tw_im   [NUM_TWIDDLES];

    for (genvar i = 0; i < BUFFER_SIZE; i++) begin : g_load
        localparam int R = bit_reverse(i, LOG_N);
        assign ld_re[i] = in_real[R*SAMPLE_SIZE +: SAMPLE_SIZE];
        assign ld_im[i] = in_imag[R*SAMPLE_SIZE +: SAMPLE_SIZE];
    end

    for (genvar i = 0; i < NUM_TWIDDLES; i++) begin : g_tw
        assign tw_re[i] = twiddles_real[i*TWIDDLE_SIZE +: TWIDDLE_SIZE];
        assign tw_im[i] = twiddles_imag[i*TWIDDLE_SIZE +: TWIDDLE_SIZE];
    end

    // Butterfly addressing: group-of-2*half layout, W_N^m with m = k*N/(2*half).
    int half, k, top, bot, tw;
    logic [LOG_N-1:0] top_idx, bot_idx;
    logic [TWW-1:0]   tw_idx;

    always_comb begin
        half    = 1 << stage;
        k       = int'(bidx) & (half - 1);
        top     = ((int'(bidx) >> stage) << (int'(stage) + 1)) + k;
        bot     = top + half;
        tw      = (k << (LOG_N - 1 - int'(stage))) * TW_STRIDE;
        top_idx = LOG_N'(top);
        bot_idx = LOG_N'(bot);
        tw_idx  = TWW'(tw);
    end

    logic signed [SAMPLE_SIZE-1:0] sum_re, sum_im, dif_re, dif_im;

    ifft_butterfly #(
        .SAMPLE_SIZE  (SAMPLE_SIZE),
        .TWIDDLE_SIZE (TWIDDLE_SIZE),
        .NO_FLOAT_MULT(NO_FLOAT_MULT)
    ) u_bfly (
        .a_re  (work_re[top_idx]),
        .a_im  (work_im[top_idx]),
        .b_re  (work_re[bot_idx]),
        .b_im  (work_im[bot_idx]),
        .w_re  (tw_re[tw_idx]),
        .w_im  (tw_im[tw_idx]),
        .sum_re(sum_re),
        .sum_im(sum_im),
        .dif_re(dif_re),
        .dif_im(dif_im)
    );

    logic last_bfly;
    assign last_bfly = (stage == LAST_STAGE) && (bidx == LAST_BIDX);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_BFLY;
`ifdef IFFT_SCALE_EN
            S_BFLY:  if (last_bfly) state_nxt = S_SCALE;
            S_SCALE: state_nxt = S_DONE;
`else
            S_BFLY:  if (last_bfly) state_nxt = S_DONE;
`endif
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next contents of the working buffer; the whole array defaults to hold.
    always_comb begin
        nxt_re = work_re;
        nxt_im = work_im;
        case (state)
            S_LOAD: begin
                nxt_re = ld_re;
                nxt_im = ld_im;
            end
            S_BFLY: begin
                nxt_re[top_idx] = sum_re;
                nxt_im[top_idx] = sum_im;
                nxt_re[bot_idx] = dif_re;
                nxt_im[bot_idx] = dif_im;
            end
`ifdef IFFT_SCALE_EN
            S_SCALE: begin
                for (int i = 0; i < BUFFER_SIZE; i++) begin
                    nxt_re[i] = work_re[i] >>> LOG_N;
                    nxt_im[i] = work_im[i] >>> LOG_N;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            stage    <= '0;
            bidx     <= '0;
            out_real <= '0;
            out_imag <= '0;
            // NOTE: the working buffer is cleared on reset so an aborted transform leaves no stale data.
            for (int i = 0; i < BUFFER_SIZE; i++) begin
                work_re[i] <= '0;
                work_im[i] <= '0;
            end
        end else begin
            state   <= state_nxt;
            work_re <= nxt_re;
            work_im <= nxt_im;
            if (state == S_LOAD) begin
                stage <= '0;
                bidx  <= '0;
            end else if (state == S_BFLY) begin
                if (bidx == LAST_BIDX) begin
                    bidx  <= '0;
                    stage <= stage + 1'b1;
                end else begin
                    bidx <= bidx + 1'b1;
                end
            end
            if (state_nxt == S_DONE) begin
                for (int i = 0; i < BUFFER_SIZE; i++) begin
                    out_real[i*SAMPLE_SIZE +: SAMPLE_SIZE] <= nxt_re[i];
                    out_imag[i*SAMPLE_SIZE +: SAMPLE_SIZE] <= nxt_im[i];
                end
            end
        end
    end

    assign busy = (state == S_LOAD) || (state == S_BFLY) || (state == S_SCALE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_ifft_n_point_seq.sv
// Scoreboard bench for ifft_n_point_seq (N=4); expectations follow IFFT_SCALE_EN.
module tb_ifft_n_point_seq;

    localparam int SS  = 32;
    localparam int N   = 4;
    localparam int TS  = 16;
    localparam int NT  = 16;
    localparam int NFM = 1000;
`ifdef IFFT_SCALE_EN
    localparam int LAT   = 6;
    localparam int SHIFT = 2;
`else
    localparam int LAT   = 5;
    localparam int SHIFT = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [N*SS-1:0]  in_real = '0, in_imag = '0;
    logic [N*SS-1:0]  out_real, out_imag;
    logic [NT*TS-1:0] twiddles_real, twiddles_imag;
    logic busy, done;

    typedef struct {
        int re[N];
        int im[N];
    } vec_t;

    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    ifft_n_point_seq #(
        .SAMPLE_SIZE(SS), .BUFFER_SIZE(N), .TWIDDLE_SIZE(TS),
        .NUM_TWIDDLES(NT), .NO_FLOAT_MULT(NFM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_real(in_real), .in_imag(in_imag),
        .twiddles_real(twiddles_real), .twiddles_imag(twiddles_imag),
        .out_real(out_real), .out_imag(out_imag),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference for N=4: hand-expanded radix-2 DIT with conj(W4^1) = +j, then /N.
    function automatic vec_t ref_ifft(input int xr[N], input int xi[N]);
        vec_t y;
        int b0r, b0i, b1r, b1i, b2r, b2i, b3r, b3i, t1r, t1i;
        b0r = xr[0] + xr[2];  b0i = xi[0] + xi[2];
        b1r = xr[0] - xr[2];  b1i = xi[0] - xi[2];
        b2r = xr[1] + xr[3];  b2i = xi[1] + xi[3];
        b3r = xr[1] - xr[3];  b3i = xi[1] - xi[3];
        t1r = -b3i;           t1i = b3r;
        y.re[0] = (b0r + b2r) >>> SHIFT;  y.im[0] = (b0i + b2i) >>> SHIFT;
        y.re[2] = (b0r - b2r) >>> SHIFT;  y.im[2] = (b0i - b2i) >>> SHIFT;
        y.re[1] = (b1r + t1r) >>> SHIFT;  y.im[1] = (b1i + t1i) >>> SHIFT;
        y.re[3] = (b1r - t1r) >>> SHIFT;  y.im[3] = (b1i - t1i) >>> SHIFT;
        return y;
    endfunction

    task automatic set_inputs(input int xr[N], input int xi[N]);
        for (int i = 0; i < N; i++) begin
            in_real[i*SS +: SS] = xr[i];
            in_imag[i*SS +: SS] = xi[i];
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            check("result_expected_on_done", longint'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                vec_t e;
                e = exp_q.pop_front();
                for (int i = 0; i < N; i++) begin
                    check($sformatf("out_real[%0d]", i), $signed(out_real[i*SS +: SS]), e.re[i]);
                    check($sformatf("out_imag[%0d]", i), $signed(out_imag[i*SS +: SS]), e.im[i]);
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || done) && n < 50);
        if (n >= 50) check("idle_timeout", 1, 0);
    endtask

    // Pulses start (sampled at edge 0) and checks done arrives after edge LAT.
    task automatic run_xfer(input int xr[N], input int xi[N], input vec_t e);
        int cyc;
        wait_idle();
        set_inputs(xr, xi);
        exp_q.push_back(e);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (cyc = 1; cyc <= LAT + 5; cyc++) begin
            @(posedge clk);
            #1;
            if (done) break;
        end
        check("done_latency", cyc, LAT);
    endtask

    initial begin
        int   xr[N], xi[N], zr[N];
        vec_t e;
        int   n_done;

        for (int i = 0; i < NT; i++) begin
            real ang, c, s;
            ang = 2.0 * 3.14159265358979 * i / (2.0 * NT);
            c = 1000.0 * $cos(ang);
            s = -1000.0 * $sin(ang);
            twiddles_real[i*TS +: TS] = TS'((c >= 0.0) ? $rtoi(c + 0.5) : $rtoi(c - 0.5));
            twiddles_imag[i*TS +: TS] = TS'((s >= 0.0) ? $rtoi(s + 0.5) : $rtoi(s - 0.5));
        end
        zr = '{0, 0, 0, 0};

        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_out_real_zero", longint'(out_real == '0), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Impulse at bin 0 gives a flat time signal.
        xr = '{4000, 0, 0, 0};
`ifdef IFFT_SCALE_EN
        e.re = '{1000, 1000, 1000, 1000};
`else
        e.re = '{4000, 4000, 4000, 4000};
`endif
        e.im = '{0, 0, 0, 0};
        run_xfer(xr, zr, e);

        // Bin 1 gives one cycle of a complex exponential; run back-to-back.
        xr = '{0, 4000, 0, 0};
`ifdef IFFT_SCALE_EN
        e.re = '{1000, 0, -1000, 0};
        e.im = '{0, 1000, 0, -1000};
`else
        e.re = '{4000, 0, -4000, 0};
        e.im = '{0, 4000, 0, -4000};
`endif
        run_xfer(xr, zr, e);

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N; i++) begin
                xr[i] = int'($urandom_range(4000, 0)) - 2000;
                xi[i] = int'($urandom_range(4000, 0)) - 2000;
            end
            run_xfer(xr, xi, ref_ifft(xr, xi));
        end

        // Cycle-accurate control timing with a second start mid-transform.
        wait_idle();
        xr = '{4000, 0, 0, 0};
        set_inputs(xr, zr);
        exp_q.push_back(ref_ifft(xr, zr));
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_done = 0;
        for (int ed = 1; ed <= LAT + 1; ed++) begin
            @(posedge clk);
            #1;
            check($sformatf("busy_after_edge%0d", ed), busy, (ed < LAT) ? 1 : 0);
            check($sformatf("done_after_edge%0d", ed), done, (ed == LAT) ? 1 : 0);
            if (done) n_done++;
            @(negedge clk);
            start = (ed == 2);
        end
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("single_done_for_double_start", n_done, 1);

        // Asynchronous reset between edges 3 and 4 aborts the transform.
        wait_idle();
        xr = '{0, 4000, 0, 0};
        set_inputs(xr, zr);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_out_real_zero", longint'(out_real == '0), 1);
        check("abort_out_imag_zero", longint'(out_imag == '0), 1);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        check("no_done_after_abort", n_done, 0);

        // Recovery after the abort.
        xr = '{100, -200, 300, -400};
        xi = '{-50, 60, -70, 80};
        run_xfer(xr, xi, ref_ifft(xr, xi));

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
